// File: rtl/gmii_tx_mux_pkg.sv
// gmii_tx_mux_pkg: shared constants, tx state enum and byte-wide reflected CRC-32 step.
package gmii_tx_mux_pkg;
   localparam logic [7:0]  PREAMBLE   = 8'h55;
   localparam logic [7:0]  SFD        = 8'hD5;
   localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

   typedef enum logic [2:0] {IDLE, PRE, DATA, PAD, FCS, IFG} tx_state_t;

   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC32_POLY : c >> 1;
      return c;
   endfunction
endpackage

// File: rtl/eth_crc32.sv
// eth_crc32: Ethernet CRC-32 register advanced one byte per enabled cycle.
module eth_crc32
   import gmii_tx_mux_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] crc
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) crc <= CRC32_INIT;
      else if (init) crc <= CRC32_INIT;
      else if (en) crc <= crc32_byte(crc, data);
endmodule

// File: rtl/gmii_tx_mux.sv
// gmii_tx_mux: grants one of three {valid,byte} reply streams and sends it on GMII TX
// with preamble, zero padding, CRC-32 FCS and inter-frame gap.
module gmii_tx_mux
   import gmii_tx_mux_pkg::*;
#(
   parameter int IFG_LEN = 12,
   parameter int MIN_LEN = 60,
   parameter int MAX_LEN = 1514
) (
   input  logic        eth_rxck,
   input  logic        rst_rx_n,
   input  logic [8:0]  rarp_i,
   input  logic [8:0]  ping_i,
   input  logic [8:0]  udp_i,
   output logic [7:0]  gmii_txd,
   output logic        gmii_txctl,
   output logic        busy,
   output logic [15:0] drop_cnt,
   output logic [15:0] trunc_cnt
);
   localparam logic [15:0] MIN_L = 16'(MIN_LEN);
   localparam logic [15:0] MAX_L = 16'(MAX_LEN);
   localparam logic [15:0] IFG_L = 16'(IFG_LEN - 1);

   tx_state_t       state, nxt;
   logic [2:0]      vld, prev, rise, win, gnt, sel, drops;
   logic            hold, in_vld, crc_init, crc_en, trunc_inc;
   logic [7:0]      in_byte, txd_nxt, crc_data;
   logic [7:0][8:0] dl;
   logic [15:0]     cnt, cnt_nxt;
   logic [16:0]     drop_sum;
   logic [31:0]     crc, fcs;

   assign vld      = {udp_i[8], ping_i[8], rarp_i[8]};
   assign rise     = vld & ~prev;
   assign win      = rise[0] ? 3'b001 : rise[1] ? 3'b010 : rise[2] ? 3'b100 : 3'b000;
   assign sel      = state == IDLE ? win : hold ? gnt : 3'b000;
   assign in_vld   = |(sel & vld);
   assign in_byte  = sel[0] ? rarp_i[7:0] : sel[1] ? ping_i[7:0] : udp_i[7:0];
   assign drops    = state == IDLE ? rise & ~win : rise;
   assign drop_sum = {1'b0, drop_cnt} + 17'(drops[0]) + 17'(drops[1]) + 17'(drops[2]);
   assign fcs      = ~crc;

   eth_crc32 u_crc (.clk(eth_rxck), .rst_n(rst_rx_n), .init(crc_init), .en(crc_en), .data(crc_data), .crc(crc));

   // cnt: preamble index in PRE, bytes sent in DATA/PAD, byte index in FCS/IFG
   always_comb begin
      nxt       = state;
      cnt_nxt   = cnt;
      txd_nxt   = 8'h00;
      crc_init  = 1'b0;
      crc_en    = 1'b0;
      crc_data  = dl[7][7:0];
      trunc_inc = 1'b0;
      case (state)
         IDLE: if (|win) begin
            nxt      = PRE;
            txd_nxt  = PREAMBLE;
            cnt_nxt  = '0;
            crc_init = 1'b1;
         end
         PRE: if (cnt == 16'd7) begin
            nxt     = DATA;
            txd_nxt = dl[7][7:0];
            cnt_nxt = 16'd1;
            crc_en  = 1'b1;
         end else begin
            txd_nxt = cnt == 16'd6 ? SFD : PREAMBLE;
            cnt_nxt = cnt + 16'd1;
         end
         DATA, PAD: begin
            trunc_inc = state == DATA && dl[7][8] && cnt >= MAX_L;
            if (state == DATA && dl[7][8] && cnt < MAX_L) begin
               txd_nxt = dl[7][7:0];
               cnt_nxt = cnt + 16'd1;
               crc_en  = 1'b1;
            end else if (cnt < MIN_L) begin
               nxt      = PAD;
               cnt_nxt  = cnt + 16'd1;
               crc_en   = 1'b1;
               crc_data = 8'h00;
            end else begin
               nxt     = FCS;
               txd_nxt = fcs[7:0];
               cnt_nxt = '0;
            end
         end
         FCS: if (cnt == 16'd3) begin
            nxt     = IFG;
            cnt_nxt = '0;
         end else begin
            txd_nxt = cnt == 16'd0 ? fcs[15:8] : cnt == 16'd1 ? fcs[23:16] : fcs[31:24];
            cnt_nxt = cnt + 16'd1;
         end
         IFG: if (cnt >= IFG_L) nxt = IDLE; else cnt_nxt = cnt + 16'd1;
         default: nxt = IDLE;
      endcase
   end

   // prev resets high so a frame already in flight at reset release never looks like a new edge
   always_ff @(posedge eth_rxck or negedge rst_rx_n)
      if (!rst_rx_n) begin
         state      <= IDLE;
         cnt        <= '0;
         gmii_txd   <= '0;
         gmii_txctl <= 1'b0;
         busy       <= 1'b0;
         prev       <= '1;
         gnt        <= '0;
         hold       <= 1'b0;
         dl         <= '0;
         drop_cnt   <= '0;
         trunc_cnt  <= '0;
      end else begin
         state      <= nxt;
         cnt        <= cnt_nxt;
         gmii_txd   <= txd_nxt;
         gmii_txctl <= nxt inside {PRE, DATA, PAD, FCS};
         busy       <= nxt != IDLE;
         prev       <= vld;
         dl         <= {dl[6:0], in_vld, in_byte};
         if (state == IDLE && |win) begin
            gnt  <= win;
            hold <= 1'b1;
         end else if (~|(gnt & vld)) hold <= 1'b0;
         drop_cnt   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         trunc_cnt  <= trunc_cnt + 16'(trunc_inc && trunc_cnt != 16'hFFFF);
      end
endmodule
